// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

  typedef enum logic [1:0] {StIdle, StSub, StMix, StDone} aes_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic bit key_bits_ok(input int unsigned kb);
    return (kb == 128) || (kb == 256);
  endfunction

  function automatic int unsigned nr_of(input int unsigned kb);
    return (kb == 128) ? 10 : 14;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2 .. x^128), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i = bits [127-8i -: 8], column-major; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly key-expansion step: next key window and the freshly expanded 128-bit round key.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int unsigned KeyBits = 256
) (
  input  logic [KeyBits-1:0] key_i,
  input  logic [31:0]        sub_i,
  input  logic [7:0]         rcon_i,
  input  logic               type_a_i,
  output logic [KeyBits-1:0] key_o,
  output logic [127:0]       rkey_o
);

  logic [127:0] base;
  logic [31:0]  rcon_word;
  logic [31:0]  n0, n1, n2, n3;

  always_comb begin
    base      = key_i[KeyBits-1 -: 128];
    rcon_word = type_a_i ? {rcon_i, 24'h0} : 32'h0;
    n0        = base[127:96] ^ sub_i ^ rcon_word;
    n1        = base[95:64] ^ n0;
    n2        = base[63:32] ^ n1;
    n3        = base[31:0] ^ n2;
    rkey_o    = {n0, n1, n2, n3};
  end

  // The 256-bit window slides by one half per step; the 128-bit window is replaced.
  if (KeyBits == 256) begin : gen_win256
    assign key_o = {key_i[127:0], rkey_o};
  end else begin : gen_win128
    assign key_o = rkey_o;
  end

endmodule

// File: rtl/aes_s4.sv
// Four parallel AES S-boxes with one registered stage; the register is deliberately unreset.
module aes_s4
  import aes_pkg::*;
(
  input  logic        clk_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] data_d, data_q;

  always_comb begin
    data_d = sub_word(data_i);
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per SUB+MIX cycle pair, keys expanded on the fly.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_state,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_state,
  output logic                busy
);

  if (!key_bits_ok(KEY_BITS)) begin : gen_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  localparam int unsigned Nr        = nr_of(KEY_BITS);
  localparam logic [3:0]  LastRound = 4'(Nr);
  localparam bit          Aes256    = (KEY_BITS == 256);

  aes_state_e          fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d, key_next;
  logic [3:0]          round_q, round_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [127:0]        out_state_q, out_state_d;
  logic                out_valid_q, out_valid_d;

  logic         accept, type_a, last_round, first_256;
  logic [127:0] sub_bytes, shifted, mixed, round_key, round_out, rkey_new;
  logic [31:0]  key_sbox_in, key_sub;

  assign in_ready   = ((fsm_q == StIdle) || ((fsm_q == StDone) && out_ready)) && rst_n;
  assign accept     = in_valid && in_ready;
  assign busy       = (fsm_q == StSub) || (fsm_q == StMix);
  assign out_valid  = out_valid_q;
  assign out_state  = out_state_q;

  assign last_round = (round_q == LastRound);
  // AES-256 round 1 uses the second key half directly; no expansion step runs.
  assign first_256  = Aes256 && (round_q == 4'd1);
  // AES-256 alternates: even rounds rotate and apply rcon, odd rounds do neither.
  assign type_a     = !Aes256 || !round_q[0];

  assign key_sbox_in = type_a ? rot_word(key_q[31:0]) : key_q[31:0];

  for (genvar c = 0; c < 4; c++) begin : gen_col_sbox
    aes_s4 u_s4 (
      .clk_i  (clk),
      .data_i (state_q[127-32*c -: 32]),
      .data_o (sub_bytes[127-32*c -: 32])
    );
  end

  aes_s4 u_key_s4 (
    .clk_i  (clk),
    .data_i (key_sbox_in),
    .data_o (key_sub)
  );

  aes_key_step #(
    .KeyBits (KEY_BITS)
  ) u_key_step (
    .key_i    (key_q),
    .sub_i    (key_sub),
    .rcon_i   (rcon_q),
    .type_a_i (type_a),
    .key_o    (key_next),
    .rkey_o   (rkey_new)
  );

  always_comb begin
    shifted = shift_rows(sub_bytes);
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    round_key = first_256 ? key_q[127:0] : rkey_new;
    round_out = (last_round ? shifted : mixed) ^ round_key;
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;

    case (fsm_q)
      StIdle: ;
      StSub:  fsm_d = StMix;
      StMix: begin
        state_d = round_out;
        if (!first_256) begin
          key_d = key_next;
          if (type_a) rcon_d = xtime(rcon_q);
        end
        if (last_round) begin
          out_state_d = round_out;
          out_valid_d = 1'b1;
          fsm_d       = StDone;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = StSub;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase

    // Acceptance overrides the DONE->IDLE move for zero-bubble back-to-back blocks.
    if (accept) begin
      state_d = in_state ^ in_key[KEY_BITS-1 -: 128];
      key_d   = in_key;
      round_d = 4'd1;
      rcon_d  = RCON_INIT;
      fsm_d   = StSub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      rcon_q      <= RCON_INIT;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances against FIPS-197 vectors and a byte model.
module tb_aes_iter_core;

  logic         clk;
  logic         rst_n;
  logic [1:0]   in_valid_v;
  logic [1:0]   in_ready_v;
  logic [1:0]   out_valid_v;
  logic [1:0]   out_ready_v;
  logic [1:0]   busy_v;
  logic [127:0] in_state;
  logic [127:0] key128;
  logic [255:0] key256;
  logic [127:0] out_state_v [2];

  int checks;
  int errors;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] C1Key  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] C3Key  =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3Ct   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BPt    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BCt    = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_iter_core #(
    .KEY_BITS (128)
  ) u_dut128 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[0]),
    .in_ready  (in_ready_v[0]),
    .in_state  (in_state),
    .in_key    (key128),
    .out_valid (out_valid_v[0]),
    .out_ready (out_ready_v[0]),
    .out_state (out_state_v[0]),
    .busy      (busy_v[0])
  );

  aes_iter_core #(
    .KEY_BITS (256)
  ) u_dut256 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_v[1]),
    .in_ready  (in_ready_v[1]),
    .in_state  (in_state),
    .in_key    (key256),
    .out_valid (out_valid_v[1]),
    .out_ready (out_ready_v[1]),
    .out_state (out_state_v[1]),
    .busy      (busy_v[1])
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Carry-less product then polynomial reduction by 0x11b.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Textbook AES: full key expansion up front, then byte-array rounds. nk = 4 or 8 words.
  function automatic logic [127:0] aes_ref(input int nk, input logic [127:0] pt,
                                           input logic [255:0] key);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_w(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_key(input int m, input logic [255:0] key);
    if (m == 0) key128 = key[255:128];
    else        key256 = key;
  endtask

  // Entered and left at a falling edge; the acceptance edge lies in between.
  task automatic send(input int m, input logic [127:0] pt, input logic [255:0] key,
                      input string tag);
    int n;
    n = 0;
    while (!in_ready_v[m] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rdy"}, 256'(in_ready_v[m]), 256'(1));
    in_state      = pt;
    set_key(m, key);
    in_valid_v[m] = 1'b1;
    @(negedge clk);
    in_valid_v[m] = 1'b0;
  endtask

  // Counts edges from acceptance to out_valid; optionally scrambles the inputs meanwhile.
  task automatic wait_out(input int m, input int lat, input logic [127:0] exp, input string tag,
                          input bit jitter);
    int cnt;
    cnt = 0;
    while (!out_valid_v[m] && cnt < 100) begin
      if (jitter) begin
        in_state      = rand128();
        set_key(m, {rand128(), rand128()});
        in_valid_v[m] = 1'b1;
      end
      @(negedge clk);
      cnt++;
      if (jitter && cnt == 5) begin
        check_eq({tag, "_busy"}, 256'(busy_v[m]), 256'(1));
        check_eq({tag, "_nrdy"}, 256'(in_ready_v[m]), 256'(0));
      end
    end
    in_valid_v[m] = 1'b0;
    check_eq({tag, "_lat"}, 256'(cnt), 256'(lat));
    check_eq({tag, "_ct"}, 256'(out_state_v[m]), 256'(exp));
  endtask

  task automatic drain(input int m, input string tag);
    out_ready_v[m] = 1'b1;
    @(negedge clk);
    out_ready_v[m] = 1'b0;
    check_eq({tag, "_vld0"}, 256'(out_valid_v[m]), 256'(0));
    check_eq({tag, "_idle"}, 256'(in_ready_v[m]), 256'(1));
    check_eq({tag, "_nbusy"}, 256'(busy_v[m]), 256'(0));
  endtask

  initial begin
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] exp;
    bit           seen;

    clk         = 1'b0;
    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    in_state    = '0;
    key128      = '0;
    key256      = '0;
    checks      = 0;
    errors      = 0;
    build_sbox();

    #1;
    check_eq("rst_rdy", 256'(in_ready_v), 256'(0));
    check_eq("rst_vld", 256'(out_valid_v), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq("post_rst_rdy", 256'(in_ready_v[m]), 256'(1));
      check_eq("post_rst_vld", 256'(out_valid_v[m]), 256'(0));
      check_eq("post_rst_busy", 256'(busy_v[m]), 256'(0));
      check_eq("post_rst_out", 256'(out_state_v[m]), 256'(0));
    end
    @(negedge clk);

    // FIPS-197 known answers.
    send(0, C1Pt, {C1Key, 128'h0}, "c1");
    wait_out(0, 20, C1Ct, "c1", 1'b0);
    drain(0, "c1");
    send(0, BPt, {BKey, 128'h0}, "appb");
    wait_out(0, 20, BCt, "appb", 1'b0);
    drain(0, "appb");
    send(1, C1Pt, C3Key, "c3");
    wait_out(1, 28, C3Ct, "c3", 1'b0);

    // Backpressure: result held, new offers refused.
    for (int i = 0; i < 10; i++) begin
      in_state      = rand128();
      key256        = {rand128(), rand128()};
      in_valid_v[1] = 1'b1;
      @(negedge clk);
      check_eq("bp_vld", 256'(out_valid_v[1]), 256'(1));
      check_eq("bp_hold", 256'(out_state_v[1]), 256'(C3Ct));
      check_eq("bp_nrdy", 256'(in_ready_v[1]), 256'(0));
    end
    in_valid_v[1] = 1'b0;
    drain(1, "bp");

    // Back-to-back: B accepted on the edge that consumes A.
    send(0, C1Pt, {C1Key, 128'h0}, "b2b_a");
    wait_out(0, 20, C1Ct, "b2b_a", 1'b0);
    in_state       = BPt;
    key128         = BKey;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b0;
    check_eq("b2b_vld0", 256'(out_valid_v[0]), 256'(0));
    check_eq("b2b_busy", 256'(busy_v[0]), 256'(1));
    wait_out(0, 20, BCt, "b2b_b", 1'b0);
    drain(0, "b2b_b");

    // Random vectors against the model, inputs scrambled after acceptance.
    for (int it = 0; it < 6; it++) begin
      int m;
      m   = it % 2;
      pt  = rand128();
      key = {rand128(), rand128()};
      exp = aes_ref((m == 0) ? 4 : 8, pt, key);
      send(m, pt, key, "rnd");
      wait_out(m, (m == 0) ? 20 : 28, exp, "rnd", 1'b1);
      drain(m, "rnd");
    end

    // Asynchronous reset around round 5 of a block in flight.
    send(0, C1Pt, {C1Key, 128'h0}, "mrst");
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq("mrst_vld", 256'(out_valid_v[m]), 256'(0));
      check_eq("mrst_out", 256'(out_state_v[m]), 256'(0));
      check_eq("mrst_busy", 256'(busy_v[m]), 256'(0));
      check_eq("mrst_nrdy", 256'(in_ready_v[m]), 256'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_v != 2'b00) seen = 1'b1;
    end
    check_eq("mrst_no_pulse", 256'(seen), 256'(0));
    check_eq("mrst_rdy", 256'(in_ready_v), 256'(2'b11));
    send(0, C1Pt, {C1Key, 128'h0}, "mrst_c1");
    wait_out(0, 20, C1Ct, "mrst_c1", 1'b0);
    drain(0, "mrst_c1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
